// File: rtl/branch_cmp_pkg.sv
// Shared op codes and helpers for the pipelined branch comparator.
package branch_cmp_pkg;

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_GE  = 3'b101;
  localparam logic [2:0] OP_LTU = 3'b110;
  localparam logic [2:0] OP_GEU = 3'b111;

  // 010 and 011 are not assigned to any branch condition
  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // Operands split into two equal halves, so WIDTH must be even and at least 4
  function automatic bit params_ok(input int width, input int stages);
    return (width >= 4) && ((width % 2) == 0) && (stages >= 2) && (stages <= 4);
  endfunction

endpackage

// File: rtl/branch_cmp_pipe_slice.sv
// One elastic valid/ready register slice: holds its payload while stalled,
// loads when empty or when the downstream slice takes the current payload.
module pipe_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  // Ready depends only on local state and downstream ready, never on in_valid
  assign in_ready = !rst && !flush && (!out_valid || out_ready);

  // Valid/payload register; reset clears both, flush only squashes valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (in_ready && in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch condition unit: evaluates EQ/NE/LT/GE/LTU/GEU on WIDTH-bit
// operands through a split-half compare, with valid/ready, flush and a tag.
module branch_cmp_pipe
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             op_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H = WIDTH / 2;

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("branch_cmp_pipe: WIDTH must be even and >= 4, STAGES must be 2..4");
  end

  typedef struct packed {
    logic             eq_hi;
    logic             eq_lo;
    logic             ltu_hi;
    logic             ltu_lo;
    logic             sign_a;
    logic             sign_b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } part_t;

  typedef struct packed {
    logic             taken;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             op_err;
    logic [TAG_W-1:0] tag;
  } res_t;

  part_t             part_d;
  part_t             part_p0;
  res_t              res_d;
  res_t              res_q [1:STAGES-1];
  logic [STAGES-1:0] vld_p;
  logic [STAGES:0]   rdy_p;

  // ---- into stage 0: half-width partial compares on the raw operands ----
  // Each half is compared independently so no full-width carry chain sits here
  always_comb begin
    part_d        = '0;
    part_d.eq_hi  = (a[WIDTH-1:H] == b[WIDTH-1:H]);
    part_d.eq_lo  = (a[H-1:0] == b[H-1:0]);
    part_d.ltu_hi = (a[WIDTH-1:H] < b[WIDTH-1:H]);
    part_d.ltu_lo = (a[H-1:0] < b[H-1:0]);
    part_d.sign_a = a[WIDTH-1];
    part_d.sign_b = b[WIDTH-1];
    part_d.op     = op;
    part_d.tag    = in_tag;
  end

  pipe_slice #(.DW($bits(part_t))) u_slice_p0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (rdy_p[0]),
    .in_data   (part_d),
    .out_valid (vld_p[0]),
    .out_ready (rdy_p[1]),
    .out_data  (part_p0)
  );

  // ---- stage 0 -> stage 1: combine halves and resolve the branch condition ----
  // Signed less-than differs from unsigned only when the sign bits differ
  always_comb begin
    res_d        = '0;
    res_d.eq     = part_p0.eq_hi & part_p0.eq_lo;
    res_d.ltu    = part_p0.ltu_hi | (part_p0.eq_hi & part_p0.ltu_lo);
    res_d.lt     = (part_p0.sign_a != part_p0.sign_b) ? part_p0.sign_a : res_d.ltu;
    res_d.op_err = is_reserved_op(part_p0.op);
    case (part_p0.op)
      OP_EQ:   res_d.taken = res_d.eq;
      OP_NE:   res_d.taken = !res_d.eq;
      OP_LT:   res_d.taken = res_d.lt;
      OP_GE:   res_d.taken = !res_d.lt;
      OP_LTU:  res_d.taken = res_d.ltu;
      OP_GEU:  res_d.taken = !res_d.ltu;
      default: res_d.taken = 1'b0;
    endcase
    res_d.tag = part_p0.tag;
  end

  // ---- stage 1 .. STAGES-1: result slices, beyond the first they only add delay ----
  for (genvar k = 1; k < STAGES; k++) begin : g_slice
    res_t slice_in;
    if (k == 1) begin : g_first
      assign slice_in = res_d;
    end else begin : g_delay
      assign slice_in = res_q[k-1];
    end

    pipe_slice #(.DW($bits(res_t))) u_slice (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld_p[k-1]),
      .in_ready  (rdy_p[k]),
      .in_data   (slice_in),
      .out_valid (vld_p[k]),
      .out_ready (rdy_p[k+1]),
      .out_data  (res_q[k])
    );
  end

  assign rdy_p[STAGES] = out_ready;
  assign in_ready      = rdy_p[0];
  assign out_valid     = vld_p[STAGES-1];
  assign taken         = res_q[STAGES-1].taken;
  assign eq            = res_q[STAGES-1].eq;
  assign lt            = res_q[STAGES-1].lt;
  assign ltu           = res_q[STAGES-1].ltu;
  assign op_err        = res_q[STAGES-1].op_err;
  assign out_tag       = res_q[STAGES-1].tag;

endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-function 32-bit equality comparator used for branch resolution.
- Evaluates all six branch conditions (EQ/NE/LT/GE/LTU/GEU) on WIDTH-bit operands.
- Split-half compare pipeline with valid/ready handshake, flush and a tag carried alongside each operation, so the EX/ID branch logic can tolerate stalls and mispredict squashes.

Parameters:
- WIDTH, 32, operand width; even, >= 4.
- STAGES, 2, pipeline depth in register slices; legal 2..4. Stage 1 holds half-compare partials, stage 2 combines, stages 3..4 are pure delay.
- TAG_W, 5, width of the sideband tag (e.g. destination/ROB id).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the operation this cycle
- op  in  3  condition code: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 reserved
- a  in  WIDTH  operand rs1
- b  in  WIDTH  operand rs2
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- taken  out  1  condition true
- eq  out  1  a == b
- lt  out  1  signed a < b
- ltu  out  1  unsigned a < b
- op_err  out  1  reserved op code received
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: all stage valid bits clear; out_valid, taken, eq, lt, ltu, op_err, out_tag = 0. in_ready = 1 the cycle after rst deasserts.
- Transfer rules:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - Payload is held stable while out_valid && !out_ready.
- Elastic pipeline:
  - Stage k loads when it is empty or stage k+1 loads/drains in the same cycle.
  - in_ready = !v[0] || stage 0 advances. No combinational path from in_valid to in_ready.
  - Full throughput is 1 op/cycle.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready stays high.
- Stage 1 registers, with H = WIDTH/2:
  - eq_hi = a[W-1:H]==b[W-1:H], eq_lo = a[H-1:0]==b[H-1:0]
  - ltu_hi (unsigned upper compare), ltu_lo (unsigned lower compare)
  - sign_a, sign_b, op, tag
- Stage 2 combines:
  - eq = eq_hi & eq_lo
  - ltu = ltu_hi | (eq_hi & ltu_lo)
  - lt = (sign_a != sign_b) ? sign_a : ltu
- taken mapping:
  - EQ → eq; NE → !eq
  - LT → lt; GE → !lt
  - LTU → ltu; GEU → !ltu
  - reserved op → taken = 0, op_err = 1; eq/lt/ltu still reported.
- Flush:
  - All valid bits clear at the next edge, and out_valid = 0 that next cycle.
  - in_ready = 0 while flush is high; a simultaneous in_valid is dropped.
  - Flush has priority over output transfer; a result presented in the flush cycle may still be taken by the consumer that cycle.
- Reset mid-operation has the same effect as flush, and also zeroes the output payload.
- Backpressure with all stages full: in_ready = 0; no loss and no duplication; order is preserved.
- Single-bit sign extraction uses bit WIDTH-1. Equal operands give lt = ltu = 0 at all widths.

Decomposition:
- Package branch_cmp_pkg:
  - op code localparams (OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU)
  - function is_reserved_op
  - a parameter-check function for legal WIDTH/STAGES
- Sub-module pipe_slice (parameter DW): one valid/ready register slice with hold-on-stall and flush.
  - Instantiated STAGES times.
  - The compare logic sits between slice 0 and slice 1.

Test Plan:
- Reset, then a=b=32'h12345678, op=EQ, out_ready=1 → out_valid exactly 2 cycles after accept, taken=1, eq=1, lt=0, ltu=0.
- a=32'hA5A5A5A5, b=32'h5A5A5A5A; issue LT, LTU, GE, NE back-to-back, tags 1..4 → taken = 1, 0, 0, 1 (signed a negative, unsigned a larger); 4 results on consecutive cycles, tags in order.
- a=32'h00000000, b=32'hFFFFFFFF; LTU then LT with out_ready=0 for 5 cycles → in_ready falls after 2 accepts; on release, results taken=1 then taken=0, no loss.
- a=b=32'hDEADBEEF with upper halves equal and lower differing (b=32'hDEADBEEE), op=GEU → eq=0, ltu=0, taken=1; op=3'b010 → op_err=1, taken=0.
- Stream 3 ops, assert flush the cycle the 3rd is accepted → out_valid=0 the next cycle, no stale result ever appears; the next new op completes normally with its own tag.
- Re-run at WIDTH=8, STAGES=4: a=8'h80, b=8'h7F, LT → taken=1, latency 4; rst asserted mid-stream → all outputs 0 the next cycle.
